// File: rtl/aes_round_scheduler_pkg.sv
// Shared types and constants for the AES round scheduler; NUM_ROUNDS may be predefined to change the round count.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

package aes_round_scheduler_pkg;

    localparam int NR     = `NUM_ROUNDS;
    localparam int RIDX_W = $clog2(`NUM_ROUNDS + 1);

    typedef logic [127:0]      state_t;
    typedef logic [127:0]      roundKey_t;
    typedef logic [RIDX_W-1:0] roundIdx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUND   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } sched_state_t;

    localparam roundIdx_t NR_IDX    = roundIdx_t'(NR);
    localparam roundIdx_t FIRST_IDX = roundIdx_t'(1);

    // Decryption walks the expanded key schedule from the top down.
    function automatic roundIdx_t key_index(input logic dec, input roundIdx_t r);
        return dec ? roundIdx_t'(NR_IDX - r) : r;
    endfunction

endpackage

// File: rtl/aes_round_scheduler.sv
// Iterative AES round scheduler driving external forward/inverse round units one round per cycle.
// Optional performance counters are enabled with AES_SCHED_PERF_EN.
module aes_round_scheduler
    import aes_round_scheduler_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  state_t      in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output state_t      out_data,
    output roundIdx_t   key_idx,
    input  roundKey_t   key_data,
    output logic        rnd_valid,
    output logic        inv_valid,
    output roundIdx_t   rnd_num,
    output state_t      rnd_in,
    output roundKey_t   rnd_key,
    input  state_t      rnd_out,
`ifdef AES_SCHED_PERF_EN
    output logic [31:0] blk_count,
    output logic [31:0] busy_cycles,
`endif
    input  state_t      inv_out
);

    sched_state_t state_q, state_d;
    roundIdx_t    round_q, round_d;
    state_t       st_q, st_d;
    logic         dec_q, dec_d;
    state_t       out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;

    logic         accept_s;
    state_t       unit_out_s;

    assign accept_s   = in_valid && in_ready;
    assign unit_out_s = dec_q ? inv_out : rnd_out;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_q     <= '0;
            st_q        <= '0;
            dec_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            st_q        <= st_d;
            dec_q       <= dec_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic; the initial AddRoundKey is folded into the accept.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        st_d        = st_q;
        dec_d       = dec_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = ROUND;
                    round_d = FIRST_IDX;
                    st_d    = in_data ^ key_data;
                    dec_d   = in_decrypt;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                if (round_q == NR_IDX) begin
                    state_d = CAPTURE;
                    round_d = '0;
                end else begin
                    round_d = round_q + FIRST_IDX;
                end
            end
            CAPTURE: begin
                out_data_d  = unit_out_s;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        state_d = ROUND;
                        round_d = FIRST_IDX;
                        st_d    = in_data ^ key_data;
                        dec_d   = in_decrypt;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                round_d     = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Handshake, key-index and round-unit drive decode.
    always_comb begin
        in_ready  = 1'b0;
        key_idx   = '0;
        rnd_valid = 1'b0;
        inv_valid = 1'b0;
        rnd_num   = '0;
        rnd_in    = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                key_idx  = key_index(in_valid && in_decrypt, roundIdx_t'(0));
            end
            ROUND: begin
                key_idx   = key_index(dec_q, round_q);
                rnd_num   = round_q;
                rnd_valid = !dec_q;
                inv_valid = dec_q;
                rnd_in    = (round_q == FIRST_IDX) ? st_q : unit_out_s;
            end
            CAPTURE: begin
                in_ready = 1'b0;
            end
            DONE: begin
                in_ready = out_ready;
                key_idx  = key_index(in_valid && in_decrypt, roundIdx_t'(0));
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign rnd_key   = key_data;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef AES_SCHED_PERF_EN
    logic [31:0] blk_count_q;
    logic [31:0] busy_cycles_q;

    // Saturating handshake and busy-cycle counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blk_count_q   <= 32'd0;
            busy_cycles_q <= 32'd0;
        end else begin
            if (out_valid_q && out_ready && (blk_count_q != 32'hFFFF_FFFF)) begin
                blk_count_q <= blk_count_q + 32'd1;
            end
            if ((state_q != IDLE) && (busy_cycles_q != 32'hFFFF_FFFF)) begin
                busy_cycles_q <= busy_cycles_q + 32'd1;
            end
        end
    end

    assign blk_count   = blk_count_q;
    assign busy_cycles = busy_cycles_q;
`endif

endmodule
